// File: rtl/seq_mem_param_rf_fwz_if.sv
// Bus bundle between the datapath (master) and the register file (slave):
// read ports, write ports and the dirty-tracking signals.
interface seq_mem_param_rf_fwz_if #(
    parameter int NUM_REGS = 8,
    parameter int NBITS    = 8,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]    read_addr;
    logic [NUM_RD*NBITS-1:0] read_data;
    logic [NUM_WR-1:0]       write_en;
    logic [NUM_WR*AW-1:0]    write_addr;
    logic [NUM_WR*NBITS-1:0] write_data;
    logic                    dirty_clear;
    logic [NUM_REGS-1:0]     dirty;

    modport master (
        output read_addr, write_en, write_addr, write_data, dirty_clear,
        input  read_data, dirty
    );

    modport slave (
        input  read_addr, write_en, write_addr, write_data, dirty_clear,
        output read_data, dirty
    );
endinterface

// File: rtl/seq_mem_param_rf_fwz.sv
// Parametrised multi-port register file with same-cycle write-to-read
// forwarding, a hard-wired zero entry and per-entry dirty tracking.
module seq_mem_param_rf_fwz #(
    parameter int NUM_REGS = 8,
    parameter int NBITS    = 8,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seq_mem_param_rf_fwz_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NBITS-1:0]    r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_dirty;
    logic [NUM_REGS-1:0] w_hit;
    logic [NBITS-1:0]    w_next [NUM_REGS];

    // w_next is both the forwarded view and the next storage contents;
    // later ports overwrite earlier ones so the highest-numbered writer wins.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_next[i] = r_mem[i];
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.write_en[w] && (bus.write_addr[w*AW +: AW] != '0)) begin
                w_hit[bus.write_addr[w*AW +: AW]]  = 1'b1;
                w_next[bus.write_addr[w*AW +: AW]] = bus.write_data[w*NBITS +: NBITS];
            end
        end
    end

    always_comb begin
        bus.read_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (bus.read_addr[p*AW +: AW] != '0) begin
                bus.read_data[p*NBITS +: NBITS] = w_next[bus.read_addr[p*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= w_next[i];
            end
        end
    end

    // A write this cycle beats a simultaneous bulk clear for that entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= w_hit | (bus.dirty_clear ? '0 : r_dirty);
        end
    end

    assign bus.dirty = r_dirty;
endmodule
